// File: rtl/gate_drive_seq.sv
// Multi-channel gate-drive sequencer: level/one-shot channels with enforced off-time and latched fault.
// Optional pairwise half-bridge interlock is compiled in with `define GATE_INTERLOCK_EN.
module gate_drive_seq #(
  parameter int N_CH         = 7,
  parameter int CLK_FREQ_MHZ = 50,
  parameter int TW           = 16,
  parameter int MIN_OFF_US   = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [N_CH-1:0]      on_en,
  input  logic [N_CH-1:0]      pulse_mode,
  input  logic [N_CH*TW-1:0]   on_time_us,
  input  logic                 fault,
  input  logic                 fault_clr,
  output logic [N_CH-1:0]      gate,
  output logic [N_CH-1:0]      status,
  output logic [N_CH-1:0]      holdoff,
  output logic                 fault_latched
);

  localparam int SW = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(CLK_FREQ_MHZ - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(MIN_OFF_US - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ON      = 2'd1,
    HOLDOFF = 2'd2
  } ch_state_e;

  ch_state_e       state_q [N_CH];
  ch_state_e       state_d [N_CH];
  logic [SW-1:0]   sub_q   [N_CH];
  logic [SW-1:0]   sub_d   [N_CH];
  logic [TW-1:0]   us_q    [N_CH];
  logic [TW-1:0]   us_d    [N_CH];
  logic [TW-1:0]   ont_q   [N_CH];
  logic [TW-1:0]   ont_d   [N_CH];
  logic [N_CH-1:0] mode_q, mode_d;
  logic [N_CH-1:0] on_en_q, rise, req, start;
  logic            armed_q;
  logic            fault_latched_q;

  // armed_q masks the first edge after reset so an on_en already high is not seen as a new edge
  always_comb begin
    rise  = on_en & ~on_en_q & {N_CH{armed_q}};
    req   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (state_q[i] == IDLE && !fault_latched_q && !fault) begin
        if (pulse_mode[i])
          req[i] = rise[i] && (on_time_us[i*TW +: TW] != '0);
        else
          req[i] = on_en[i];
      end
    end
    start = req;
`ifdef GATE_INTERLOCK_EN
    for (int k = 0; k < N_CH / 2; k++) begin
      if (state_q[2*k+1] != IDLE)
        start[2*k] = 1'b0;
      if (state_q[2*k] != IDLE || req[2*k])
        start[2*k+1] = 1'b0;
    end
`endif
  end

  // counters only advance while a timed interval runs, so a long level-mode ON never wraps them
  always_comb begin
    mode_d = mode_q;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      sub_d[i]   = sub_q[i];
      us_d[i]    = us_q[i];
      ont_d[i]   = ont_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (start[i]) begin
            state_d[i] = ON;
            sub_d[i]   = '0;
            us_d[i]    = '0;
            mode_d[i]  = pulse_mode[i];
            ont_d[i]   = on_time_us[i*TW +: TW];
          end
        end
        ON: begin
          if (fault || (!mode_q[i] && !on_en[i]) ||
              (mode_q[i] && sub_q[i] == SUB_LAST && us_q[i] == ont_q[i] - 1'b1)) begin
            state_d[i] = HOLDOFF;
            sub_d[i]   = '0;
            us_d[i]    = '0;
          end else if (mode_q[i]) begin
            if (sub_q[i] == SUB_LAST) begin
              sub_d[i] = '0;
              us_d[i]  = us_q[i] + 1'b1;
            end else begin
              sub_d[i] = sub_q[i] + 1'b1;
            end
          end
        end
        HOLDOFF: begin
          if (sub_q[i] == SUB_LAST && us_q[i] == OFF_LAST) begin
            state_d[i] = IDLE;
            sub_d[i]   = '0;
            us_d[i]    = '0;
          end else if (sub_q[i] == SUB_LAST) begin
            sub_d[i] = '0;
            us_d[i]  = us_q[i] + 1'b1;
          end else begin
            sub_d[i] = sub_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          sub_d[i]   = '0;
          us_d[i]    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= IDLE;
        sub_q[i]   <= '0;
        us_q[i]    <= '0;
        ont_q[i]   <= '0;
      end
      mode_q          <= '0;
      on_en_q         <= '0;
      armed_q         <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        sub_q[i]   <= sub_d[i];
        us_q[i]    <= us_d[i];
        ont_q[i]   <= ont_d[i];
      end
      mode_q  <= mode_d;
      on_en_q <= on_en;
      armed_q <= 1'b1;
      if (fault)
        fault_latched_q <= 1'b1;
      else if (fault_clr)
        fault_latched_q <= 1'b0;
    end
  end

  always_comb begin
    gate    = '0;
    holdoff = '0;
    for (int i = 0; i < N_CH; i++) begin
      gate[i]    = (state_q[i] == ON);
      holdoff[i] = (state_q[i] == HOLDOFF);
    end
  end

  assign status        = gate;
  assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_gate_drive_seq.sv
// Randomized and directed bench for gate_drive_seq, checked against a cycle-countdown reference model.
module tb_gate_drive_seq;

  localparam int N_CH         = 7;
  localparam int CLK_FREQ_MHZ = 50;
  localparam int TW           = 16;
  localparam int MIN_OFF_US   = 2;
  localparam int OFF_CYC      = MIN_OFF_US * CLK_FREQ_MHZ;

  logic                 sys_clk = 1'b0;
  logic                 sys_rst_n = 1'b0;
  logic [N_CH-1:0]      on_en = '0;
  logic [N_CH-1:0]      pulse_mode = '0;
  logic [N_CH*TW-1:0]   on_time_us = '0;
  logic                 fault = 1'b0;
  logic                 fault_clr = 1'b0;
  logic [N_CH-1:0]      gate, status, holdoff;
  logic                 fault_latched;

  gate_drive_seq #(
    .N_CH(N_CH), .CLK_FREQ_MHZ(CLK_FREQ_MHZ), .TW(TW), .MIN_OFF_US(MIN_OFF_US)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .on_en(on_en), .pulse_mode(pulse_mode),
    .on_time_us(on_time_us), .fault(fault), .fault_clr(fault_clr), .gate(gate),
    .status(status), .holdoff(holdoff), .fault_latched(fault_latched)
  );

  always #10 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: phase 0 idle, 1 on, 2 holdoff; remain counts cycles left in a timed phase
  int              m_phase  [N_CH];
  int              m_remain [N_CH];
  bit              m_pulse  [N_CH];
  logic [N_CH-1:0] m_prev;
  bit              m_prev_ok;
  bit              m_fault;

  int              cyc, t_fall0, t_rise0;
  int              hi_cnt [N_CH];
  int              ho_cnt [N_CH];
  logic            prev_g0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int field(input int i);
    return int'(on_time_us[i*TW +: TW]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_phase[i]  = 0;
      m_remain[i] = 0;
      m_pulse[i]  = 1'b0;
    end
    m_prev    = '0;
    m_prev_ok = 1'b0;
    m_fault   = 1'b0;
  endtask

  task automatic model_step();
    logic [N_CH-1:0] want, grant;
    bit blk;
    blk  = m_fault || fault;
    want = '0;
    for (int i = 0; i < N_CH; i++)
      if (m_phase[i] == 0 && !blk)
        want[i] = pulse_mode[i] ? (m_prev_ok && on_en[i] && !m_prev[i] && field(i) != 0) : on_en[i];
    grant = want;
`ifdef GATE_INTERLOCK_EN
    for (int k = 0; k < N_CH / 2; k++) begin
      if (m_phase[2*k+1] != 0) grant[2*k] = 1'b0;
      if (m_phase[2*k] != 0 || want[2*k]) grant[2*k+1] = 1'b0;
    end
`endif
    for (int i = 0; i < N_CH; i++) begin
      case (m_phase[i])
        0: if (grant[i]) begin
          m_phase[i]  = 1;
          m_pulse[i]  = pulse_mode[i];
          m_remain[i] = field(i) * CLK_FREQ_MHZ;
        end
        1: begin
          if (m_pulse[i]) m_remain[i]--;
          if (fault || (!m_pulse[i] && !on_en[i]) || (m_pulse[i] && m_remain[i] == 0)) begin
            m_phase[i]  = 2;
            m_remain[i] = OFF_CYC;
          end
        end
        default: begin
          m_remain[i]--;
          if (m_remain[i] == 0) m_phase[i] = 0;
        end
      endcase
    end
    if (fault) m_fault = 1'b1;
    else if (fault_clr) m_fault = 1'b0;
    m_prev    = on_en;
    m_prev_ok = 1'b1;
  endtask

  task automatic compare_all(input string tag);
    logic [N_CH-1:0] eg, eh;
    for (int i = 0; i < N_CH; i++) begin
      eg[i] = (m_phase[i] == 1);
      eh[i] = (m_phase[i] == 2);
    end
    checkOutput({tag, ".gate"}, 32'(gate), 32'(eg));
    checkOutput({tag, ".status"}, 32'(status), 32'(eg));
    checkOutput({tag, ".holdoff"}, 32'(holdoff), 32'(eh));
    checkOutput({tag, ".fault_latched"}, 32'(fault_latched), 32'(m_fault));
  endtask

  // one cycle: drive at the negedge, step the model on the posedge, compare at the next negedge
  task automatic applyStimulus(input string tag, input logic [N_CH-1:0] en, input logic f, input logic fc);
    on_en     = en;
    fault     = f;
    fault_clr = fc;
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    cyc++;
    compare_all(tag);
    for (int i = 0; i < N_CH; i++) begin
      if (gate[i]) hi_cnt[i]++;
      if (holdoff[i]) ho_cnt[i]++;
    end
    if (prev_g0 && !gate[0]) t_fall0 = cyc;
    if (!prev_g0 && gate[0]) t_rise0 = cyc;
    prev_g0 = gate[0];
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N_CH; i++) begin
      hi_cnt[i] = 0;
      ho_cnt[i] = 0;
    end
  endtask

  task automatic set_time(input int i, input int t);
    on_time_us[i*TW +: TW] = TW'(t);
  endtask

  initial begin
    logic [N_CH-1:0] en;
    logic [1:0] g23;
    cyc = 0; t_fall0 = 0; t_rise0 = 0; prev_g0 = 1'b0;
    clear_counts();
    model_reset();

    repeat (3) @(negedge sys_clk);
    compare_all("reset");
    sys_rst_n = 1'b1;

    // level mode on channel 0
    clear_counts();
    repeat (100) applyStimulus("lvl_on", 7'b0000001, 1'b0, 1'b0);
    checkOutput("lvl_high_cycles", 32'(hi_cnt[0]), 32'd100);
    clear_counts();
    repeat (5) applyStimulus("lvl_off", 7'b0000000, 1'b0, 1'b0);
    repeat (110) applyStimulus("lvl_reon", 7'b0000001, 1'b0, 1'b0);
    checkOutput("lvl_holdoff_cycles", 32'(ho_cnt[0]), 32'(OFF_CYC));
    checkOutput("lvl_gap", 32'(t_rise0 - t_fall0), 32'(OFF_CYC + 1));
    repeat (110) applyStimulus("lvl_idle", 7'b0000000, 1'b0, 1'b0);

    // pulse mode on channel 1, retrigger during ON ignored
    pulse_mode = 7'b0000010;
    set_time(1, 3);
    clear_counts();
    applyStimulus("pls_trig", 7'b0000010, 1'b0, 1'b0);
    repeat (38) applyStimulus("pls_run", 7'b0000000, 1'b0, 1'b0);
    set_time(1, 1);
    applyStimulus("pls_retrig", 7'b0000010, 1'b0, 1'b0);
    repeat (260) applyStimulus("pls_tail", 7'b0000000, 1'b0, 1'b0);
    checkOutput("pls_width", 32'(hi_cnt[1]), 32'd150);
    set_time(1, 0);
    clear_counts();
    applyStimulus("pls_zero", 7'b0000010, 1'b0, 1'b0);
    repeat (10) applyStimulus("pls_zero_w", 7'b0000000, 1'b0, 1'b0);
    checkOutput("pls_zero_width", 32'(hi_cnt[1]), 32'd0);

    // fault during a channel-1 pulse
    set_time(1, 3);
    applyStimulus("flt_trig", 7'b0000010, 1'b0, 1'b0);
    repeat (59) applyStimulus("flt_run", 7'b0000000, 1'b0, 1'b0);
    applyStimulus("flt_hit", 7'b0000000, 1'b1, 1'b0);
    checkOutput("flt_gate_drop", 32'(gate[1]), 32'd0);
    checkOutput("flt_latched", 32'(fault_latched), 32'd1);
    clear_counts();
    repeat (10) applyStimulus("flt_block", 7'b0000001, 1'b0, 1'b0);
    checkOutput("flt_blocked", 32'(hi_cnt[0]), 32'd0);
    applyStimulus("flt_clr_busy", 7'b0000001, 1'b1, 1'b1);
    checkOutput("flt_fault_wins", 32'(fault_latched), 32'd1);
    applyStimulus("flt_clr", 7'b0000001, 1'b0, 1'b1);
    repeat (5) applyStimulus("flt_after", 7'b0000001, 1'b0, 1'b0);
    checkOutput("flt_reenabled", 32'(gate[0]), 32'd1);
    repeat (120) applyStimulus("flt_idle", 7'b0000000, 1'b0, 1'b0);

    // pair (2,3): sequential and simultaneous requests
    pulse_mode = '0;
    repeat (20) applyStimulus("il_ch2", 7'b0000100, 1'b0, 1'b0);
    repeat (20) applyStimulus("il_both", 7'b0001100, 1'b0, 1'b0);
    repeat (130) applyStimulus("il_ch3", 7'b0001000, 1'b0, 1'b0);
    repeat (120) applyStimulus("il_idle", 7'b0000000, 1'b0, 1'b0);
    applyStimulus("il_simul", 7'b0001100, 1'b0, 1'b0);
    g23 = gate[3:2];
`ifdef GATE_INTERLOCK_EN
    checkOutput("il_even_wins", 32'(g23), 32'd1);
`else
    checkOutput("il_independent", 32'(g23), 32'd3);
`endif
    repeat (120) applyStimulus("il_done", 7'b0000000, 1'b0, 1'b0);

    // asynchronous reset in the middle of a channel-4 pulse
    pulse_mode = 7'b0010000;
    set_time(4, 2);
    applyStimulus("rst_trig", 7'b0010000, 1'b0, 1'b0);
    repeat (30) applyStimulus("rst_run", 7'b0010000, 1'b0, 1'b0);
    #3 sys_rst_n = 1'b0;
    #1;
    checkOutput("rst_gate", 32'(gate), 32'd0);
    checkOutput("rst_holdoff", 32'(holdoff), 32'd0);
    checkOutput("rst_status", 32'(status), 32'd0);
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    prev_g0 = 1'b0;
    clear_counts();
    repeat (120) applyStimulus("rst_held", 7'b0010000, 1'b0, 1'b0);
    checkOutput("rst_no_pulse", 32'(hi_cnt[4]), 32'd0);
    applyStimulus("rst_low", 7'b0000000, 1'b0, 1'b0);
    applyStimulus("rst_edge", 7'b0010000, 1'b0, 1'b0);
    checkOutput("rst_new_edge", 32'(gate[4]), 32'd1);
    repeat (220) applyStimulus("rst_done", 7'b0000000, 1'b0, 1'b0);

    // randomized traffic
    en = '0;
    for (int c = 0; c < 15000; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 399) == 0) pulse_mode[i] = ~pulse_mode[i];
        if ($urandom_range(0, 99) == 0) set_time(i, int'($urandom_range(0, 3)));
      end
      applyStimulus("rand", en, ($urandom_range(0, 799) == 0), ($urandom_range(0, 59) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
